// File: rtl/fare_ledger_if.sv
// Fare-protocol and station-admin bus between the gate/admin side (master) and fare_ledger (slave).
interface fare_ledger_if #(
  parameter int unsigned ID_W  = 3,
  parameter int unsigned BAL_W = 12
);
  logic             nfc;
  logic [ID_W-1:0]  card_id;
  logic             reduce_bal;
  logic             topup_valid;
  logic [ID_W-1:0]  topup_id;
  logic [BAL_W-1:0] topup_amt;
  logic             prov_valid;
  logic [ID_W-1:0]  prov_id;
  logic             prov_active;
  logic             prov_monthly;
  logic             card_active;
  logic             monthly;
  logic             fund_enough;
  logic [BAL_W-1:0] bal_out;
  logic             busy;
  logic             deduct_done;
  logic             err_underflow;

  modport master (
    output nfc, card_id, reduce_bal, topup_valid, topup_id, topup_amt,
           prov_valid, prov_id, prov_active, prov_monthly,
    input  card_active, monthly, fund_enough, bal_out, busy, deduct_done, err_underflow
  );

  modport slave (
    input  nfc, card_id, reduce_bal, topup_valid, topup_id, topup_amt,
           prov_valid, prov_id, prov_active, prov_monthly,
    output card_active, monthly, fund_enough, bal_out, busy, deduct_done, err_underflow
  );
endinterface

// File: rtl/fare_ledger.sv
// Card ledger responder: snapshots qualifiers on a tap, deducts the fare on reduce_bal,
// and applies admin top-ups / provisioning on any cycle.
module fare_ledger #(
  parameter int unsigned NUM_CARDS   = 8,
  parameter int unsigned ID_W        = 3,
  parameter int unsigned BAL_W       = 12,
  parameter int unsigned FARE        = 300,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic         clk,
  input  logic         reset,
  fare_ledger_if.slave bus
);
  localparam int unsigned TMR_W = $clog2(HOLD_CYCLES);
  localparam int unsigned SUM_W = BAL_W + 1;
  localparam logic [BAL_W-1:0] FARE_V    = BAL_W'(FARE);
  localparam logic [BAL_W-1:0] BAL_MAX   = {BAL_W{1'b1}};
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DEDUCT} state_t;

  state_t state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d;

  logic [NUM_CARDS-1:0][BAL_W-1:0] led_bal_q, led_bal_d;
  logic [NUM_CARDS-1:0]            led_act_q, led_act_d;
  logic [NUM_CARDS-1:0]            led_mon_q, led_mon_d;

  logic             card_active_q, card_active_d;
  logic             monthly_q, monthly_d;
  logic             fund_enough_q, fund_enough_d;
  logic [BAL_W-1:0] bal_out_q, bal_out_d;
  logic             busy_q, busy_d;
  logic             deduct_done_q, deduct_done_d;
  logic             err_underflow_q, err_underflow_d;

  logic             tap_act, tap_mon, cur_act, cur_mon, deduct_ok;
  logic [BAL_W-1:0] tap_bal, cur_bal;
  logic [SUM_W-1:0] sum;

  // Ledger reads for the tapped id and the open transaction; unmatched ids read as empty.
  always_comb begin : ledger_read
    tap_act = 1'b0;
    tap_mon = 1'b0;
    tap_bal = '0;
    cur_act = 1'b0;
    cur_mon = 1'b0;
    cur_bal = '0;
    for (int i = 0; i < int'(NUM_CARDS); i++) begin
      if (bus.card_id == ID_W'(i)) begin
        tap_act = led_act_q[i];
        tap_mon = led_mon_q[i];
        tap_bal = led_bal_q[i];
      end
      if (cur_id_q == ID_W'(i)) begin
        cur_act = led_act_q[i];
        cur_mon = led_mon_q[i];
        cur_bal = led_bal_q[i];
      end
    end
  end

  always_comb begin : next_state
    state_d         = state_q;
    timer_d         = timer_q;
    cur_id_d        = cur_id_q;
    card_active_d   = card_active_q;
    monthly_d       = monthly_q;
    fund_enough_d   = fund_enough_q;
    bal_out_d       = bal_out_q;
    busy_d          = busy_q;
    deduct_done_d   = 1'b0;
    err_underflow_d = 1'b0;
    deduct_ok       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.nfc) begin
          state_d       = S_HOLD;
          timer_d       = '0;
          cur_id_d      = bus.card_id;
          card_active_d = tap_act;
          monthly_d     = tap_mon & tap_act;
          fund_enough_d = (tap_bal >= FARE_V) & tap_act;
          bal_out_d     = tap_bal;
          busy_d        = 1'b1;
        end else begin
          card_active_d = 1'b0;
          monthly_d     = 1'b0;
          fund_enough_d = 1'b0;
          bal_out_d     = '0;
          busy_d        = 1'b0;
        end
      end
      S_HOLD: begin
        if (bus.reduce_bal) begin
          state_d = S_DEDUCT;
        end else if (timer_q == HOLD_LAST) begin
          state_d       = S_IDLE;
          card_active_d = 1'b0;
          monthly_d     = 1'b0;
          fund_enough_d = 1'b0;
          bal_out_d     = '0;
          busy_d        = 1'b0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DEDUCT: begin
        // Outputs stay visible for one more cycle; the idle edge clears them.
        state_d = S_IDLE;
        if (!cur_act) begin
          err_underflow_d = 1'b1;
        end else if (cur_mon) begin
          deduct_done_d = 1'b1;
        end else if (cur_bal >= FARE_V) begin
          deduct_ok     = 1'b1;
          deduct_done_d = 1'b1;
          bal_out_d     = cur_bal - FARE_V;
        end else begin
          err_underflow_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Deduct first, then saturating top-up, so a coincident pair yields sat(bal - FARE + amt).
  always_comb begin : ledger_next
    led_bal_d = led_bal_q;
    led_act_d = led_act_q;
    led_mon_d = led_mon_q;
    sum       = '0;
    for (int i = 0; i < int'(NUM_CARDS); i++) begin
      sum = {1'b0, led_bal_q[i]};
      if (deduct_ok && (cur_id_q == ID_W'(i))) begin
        sum = sum - SUM_W'(FARE);
      end
      if (bus.topup_valid && (bus.topup_id == ID_W'(i))) begin
        sum = sum + {1'b0, bus.topup_amt};
      end
      led_bal_d[i] = sum[BAL_W] ? BAL_MAX : sum[BAL_W-1:0];
      if (bus.prov_valid && (bus.prov_id == ID_W'(i))) begin
        led_act_d[i] = bus.prov_active;
        led_mon_d[i] = bus.prov_monthly;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      cur_id_q        <= '0;
      led_bal_q       <= '0;
      led_act_q       <= '0;
      led_mon_q       <= '0;
      card_active_q   <= 1'b0;
      monthly_q       <= 1'b0;
      fund_enough_q   <= 1'b0;
      bal_out_q       <= '0;
      busy_q          <= 1'b0;
      deduct_done_q   <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      cur_id_q        <= cur_id_d;
      led_bal_q       <= led_bal_d;
      led_act_q       <= led_act_d;
      led_mon_q       <= led_mon_d;
      card_active_q   <= card_active_d;
      monthly_q       <= monthly_d;
      fund_enough_q   <= fund_enough_d;
      bal_out_q       <= bal_out_d;
      busy_q          <= busy_d;
      deduct_done_q   <= deduct_done_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign bus.card_active   = card_active_q;
  assign bus.monthly       = monthly_q;
  assign bus.fund_enough   = fund_enough_q;
  assign bus.bal_out       = bal_out_q;
  assign bus.busy          = busy_q;
  assign bus.deduct_done   = deduct_done_q;
  assign bus.err_underflow = err_underflow_q;
endmodule

// File: tb/tb_fare_ledger.sv
// Directed table-driven bench for fare_ledger plus hand sequences for hold timeout and async reset.
module tb_fare_ledger;
  localparam logic [2:0] K_NOP  = 3'd0;
  localparam logic [2:0] K_TAP  = 3'd1;
  localparam logic [2:0] K_RED  = 3'd2;
  localparam logic [2:0] K_TOP  = 3'd3;
  localparam logic [2:0] K_PROV = 3'd4;
  localparam logic [2:0] K_PT   = 3'd5;

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  id;
    logic [11:0] val;
    logic [17:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  vec_t vecs[$];

  fare_ledger_if #(.ID_W(3), .BAL_W(12)) bus ();

  fare_ledger dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs packed as {card_active, monthly, fund_enough, bal_out, busy, deduct_done, err_underflow}.
  function automatic logic [17:0] o(input logic ca, input logic mo, input logic fe,
                                    input logic [11:0] b, input logic bz,
                                    input logic dd, input logic eu);
    return {ca, mo, fe, b, bz, dd, eu};
  endfunction

  function automatic logic [17:0] outs();
    return {bus.card_active, bus.monthly, bus.fund_enough, bus.bal_out,
            bus.busy, bus.deduct_done, bus.err_underflow};
  endfunction

  task automatic row(input logic [2:0] kind, input logic [2:0] id,
                     input logic [11:0] val, input logic [17:0] exp);
    vec_t v;
    v.kind = kind;
    v.id   = id;
    v.val  = val;
    v.exp  = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] kind, input logic [2:0] id, input logic [11:0] val);
    bus.nfc          = 1'b0;
    bus.card_id      = '0;
    bus.reduce_bal   = 1'b0;
    bus.topup_valid  = 1'b0;
    bus.topup_id     = '0;
    bus.topup_amt    = '0;
    bus.prov_valid   = 1'b0;
    bus.prov_id      = '0;
    bus.prov_active  = 1'b0;
    bus.prov_monthly = 1'b0;
    case (kind)
      K_TAP: begin bus.nfc = 1'b1; bus.card_id = id; end
      K_RED: bus.reduce_bal = 1'b1;
      K_TOP: begin bus.topup_valid = 1'b1; bus.topup_id = id; bus.topup_amt = val; end
      K_PROV: begin
        bus.prov_valid = 1'b1; bus.prov_id = id;
        bus.prov_active = val[0]; bus.prov_monthly = val[1];
      end
      K_PT: begin
        bus.prov_valid = 1'b1; bus.prov_id = id; bus.prov_active = 1'b1;
        bus.topup_valid = 1'b1; bus.topup_id = id; bus.topup_amt = val;
      end
      default: ;
    endcase
  endtask

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got ca=%b mo=%b fe=%b bal=%0d busy=%b dd=%b eu=%b, want ca=%b mo=%b fe=%b bal=%0d busy=%b dd=%b eu=%b",
               name, got[17], got[16], got[15], got[14:3], got[2], got[1], got[0],
               exp[17], exp[16], exp[15], exp[14:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Apply one cycle of stimulus and sample just after the edge it takes effect on.
  task automatic step(input logic [2:0] kind, input logic [2:0] id, input logic [11:0] val);
    drive(kind, id, val);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [17:0] z;
    total = 0;
    bad   = 0;
    z     = '0;

    // Provision + top-up, tap, accepted deduct.
    row(K_PROV, 3'd2, 12'd1,   z);
    row(K_TOP,  3'd2, 12'd500, z);
    row(K_TAP,  3'd2, 12'd0,   o(1, 0, 1, 12'd500, 1, 0, 0));
    row(K_RED,  3'd0, 12'd0,   o(1, 0, 1, 12'd500, 1, 0, 0));
    row(K_NOP,  3'd0, 12'd0,   o(1, 0, 1, 12'd200, 1, 1, 0));
    row(K_NOP,  3'd0, 12'd0,   z);
    row(K_RED,  3'd0, 12'd0,   z);
    // Insufficient funds at 200.
    row(K_TAP,  3'd2, 12'd0,   o(1, 0, 0, 12'd200, 1, 0, 0));
    row(K_RED,  3'd0, 12'd0,   o(1, 0, 0, 12'd200, 1, 0, 0));
    row(K_NOP,  3'd0, 12'd0,   o(1, 0, 0, 12'd200, 1, 0, 1));
    row(K_NOP,  3'd0, 12'd0,   z);
    // Monthly pass with zero balance.
    row(K_PROV, 3'd5, 12'd3,   z);
    row(K_TAP,  3'd5, 12'd0,   o(1, 1, 0, 12'd0, 1, 0, 0));
    row(K_RED,  3'd0, 12'd0,   o(1, 1, 0, 12'd0, 1, 0, 0));
    row(K_NOP,  3'd0, 12'd0,   o(1, 1, 0, 12'd0, 1, 1, 0));
    row(K_NOP,  3'd0, 12'd0,   z);
    // Unprovisioned card.
    row(K_TAP,  3'd7, 12'd0,   o(0, 0, 0, 12'd0, 1, 0, 0));
    row(K_RED,  3'd0, 12'd0,   o(0, 0, 0, 12'd0, 1, 0, 0));
    row(K_NOP,  3'd0, 12'd0,   o(0, 0, 0, 12'd0, 1, 0, 1));
    row(K_NOP,  3'd0, 12'd0,   z);
    // Exact-fare deduct with a coincident top-up: 300 - 300 + 100 = 100.
    row(K_TOP,  3'd2, 12'd100, z);
    row(K_TAP,  3'd2, 12'd0,   o(1, 0, 1, 12'd300, 1, 0, 0));
    row(K_RED,  3'd0, 12'd0,   o(1, 0, 1, 12'd300, 1, 0, 0));
    row(K_TOP,  3'd2, 12'd100, o(1, 0, 1, 12'd0, 1, 1, 0));
    row(K_NOP,  3'd0, 12'd0,   z);
    // Top-up during hold leaves the snapshot alone; ledger reaches 200, still short.
    row(K_TAP,  3'd2, 12'd0,   o(1, 0, 0, 12'd100, 1, 0, 0));
    row(K_TOP,  3'd2, 12'd100, o(1, 0, 0, 12'd100, 1, 0, 0));
    row(K_RED,  3'd0, 12'd0,   o(1, 0, 0, 12'd100, 1, 0, 0));
    row(K_NOP,  3'd0, 12'd0,   o(1, 0, 0, 12'd100, 1, 0, 1));
    row(K_NOP,  3'd0, 12'd0,   z);
    // Saturating top-up 4000 onto 200; nfc ignored while holding.
    row(K_TOP,  3'd2, 12'd4000, z);
    row(K_TAP,  3'd2, 12'd0,   o(1, 0, 1, 12'd4095, 1, 0, 0));
    row(K_TAP,  3'd5, 12'd0,   o(1, 0, 1, 12'd4095, 1, 0, 0));
    row(K_RED,  3'd0, 12'd0,   o(1, 0, 1, 12'd4095, 1, 0, 0));
    row(K_NOP,  3'd0, 12'd0,   o(1, 0, 1, 12'd3795, 1, 1, 0));
    row(K_NOP,  3'd0, 12'd0,   z);
    // Simultaneous provisioning and top-up on the same id.
    row(K_PT,   3'd3, 12'd400, z);
    row(K_TAP,  3'd3, 12'd0,   o(1, 0, 1, 12'd400, 1, 0, 0));
    row(K_RED,  3'd0, 12'd0,   o(1, 0, 1, 12'd400, 1, 0, 0));
    row(K_NOP,  3'd0, 12'd0,   o(1, 0, 1, 12'd100, 1, 1, 0));
    row(K_NOP,  3'd0, 12'd0,   z);

    drive(K_NOP, 3'd0, 12'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", outs(), z);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].kind, vecs[i].id, vecs[i].val);
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Hold timeout on id2 (3795): eight hold cycles, then idle with no pulse or deduct.
    step(K_TAP, 3'd2, 12'd0);
    check("timeout_tap", outs(), o(1, 0, 1, 12'd3795, 1, 0, 0));
    for (int c = 0; c < 7; c++) begin
      step(K_NOP, 3'd0, 12'd0);
      check($sformatf("timeout_hold%0d", c), outs(), o(1, 0, 1, 12'd3795, 1, 0, 0));
    end
    step(K_NOP, 3'd0, 12'd0);
    check("timeout_exit", outs(), z);
    step(K_NOP, 3'd0, 12'd0);
    check("timeout_quiet", outs(), z);
    step(K_TAP, 3'd2, 12'd0);
    check("timeout_bal_kept", outs(), o(1, 0, 1, 12'd3795, 1, 0, 0));

    // Async reset mid-hold clears outputs before the next clock edge.
    drive(K_NOP, 3'd0, 12'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", outs(), z);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int id = 0; id < 8; id++) begin
      step(K_TAP, 3'(id), 12'd0);
      check($sformatf("cleared_id%0d", id), outs(), o(0, 0, 0, 12'd0, 1, 0, 0));
      step(K_RED, 3'd0, 12'd0);
      step(K_NOP, 3'd0, 12'd0);
      step(K_NOP, 3'd0, 12'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
